// File: rtl/note_seq_pkg.sv
// ---------------------------------------------------------------------------
// note_seq_pkg
// Shared definitions for the note sequencer: opcode values, instruction
// field positions, FSM state encoding and the tick denominator helper.
//
// Instruction word:
//   [15:14] op   00 NOTE  : [13:12] ch, [11:4] pitch, [3:0] dur
//                01 JUMP  : [13:0]  target address
//                10 TEMPO : [8:0]   bpm
//                11 END
// ---------------------------------------------------------------------------
package note_seq_pkg;

    localparam logic [1:0] OP_NOTE  = 2'b00;
    localparam logic [1:0] OP_JUMP  = 2'b01;
    localparam logic [1:0] OP_TEMPO = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

    localparam int OP_MSB     = 15;
    localparam int OP_LSB     = 14;
    localparam int CH_MSB     = 13;
    localparam int CH_LSB     = 12;
    localparam int PITCH_MSB  = 11;
    localparam int PITCH_LSB  = 4;
    localparam int DUR_MSB    = 3;
    localparam int DUR_LSB    = 0;
    localparam int TARGET_MSB = 13;
    localparam int TEMPO_MSB  = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WAIT  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    // Cycles per quarter beat are clk_hz*60/(4*bpm); the accumulator compares
    // against clk_hz*15 so that bpm can be added directly every cycle.
    function automatic logic [31:0] tick_den(input int unsigned clk_hz);
        return 32'(clk_hz * 32'd15);
    endfunction

endpackage

// File: rtl/tone_channel.sv
// ---------------------------------------------------------------------------
// tone_channel
// One square-wave tone generator. The half period is pitch*PERIOD_UNIT
// cycles; pitch 0 means silent (wave held at 0).
//
// Ports:
//   clk, rst  system clock, asynchronous active-high reset
//   load      take a new pitch this cycle
//   pitch     pitch code (0 = silence)
//   wave      registered square-wave output
// ---------------------------------------------------------------------------
module tone_channel #(
    parameter int PERIOD_UNIT = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] pitch,
    output logic       wave
);

    localparam int CW = 8 + $clog2(PERIOD_UNIT) + 1;

    logic [7:0]    cur_pitch;
    logic [CW-1:0] cnt;
    logic [CW-1:0] half_period;

    assign half_period = CW'(cur_pitch) * CW'(PERIOD_UNIT);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_pitch <= '0;
            cnt       <= '0;
            wave      <= 1'b0;
        end else if (load && (pitch != cur_pitch)) begin
            // Only a different pitch restarts the phase; reloading the same
            // pitch falls through to the free-running branch below.
            cur_pitch <= pitch;
            cnt       <= '0;
            wave      <= 1'b0;
        end else if (cur_pitch != 8'd0) begin
            if (cnt == half_period - CW'(1)) begin
                cnt  <= '0;
                wave <= ~wave;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
// Fetches 16-bit note instructions from asynchronous SRAM and plays them on
// CHANNELS square-wave tone channels at a programmable tempo.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   start           one-cycle pulse, starts playback at address 0 when idle
//   sram_addr       registered SRAM word address
//   sram_WE/CE/OE/LB/UB  constant read-only SRAM controls (1,0,0,0,0)
//   sram_io         SRAM read data
//   chan_out        per-channel square waves
//   speaker         OR of all channel waves
//   busy            playback in progress
//   LED             at least one channel has a non-zero pitch
//   LED2            halted after END
//
// Build option: define NOTE_SEQ_JUMP_EN to make JUMP load the PC from the
// target field; without it JUMP behaves as a NOP.
// ---------------------------------------------------------------------------
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int CHANNELS    = 2,
    parameter int ADDR_W      = 18,
    parameter int SRAM_WAIT   = 2,
    parameter int PERIOD_UNIT = 512,
    parameter int BPM         = 96
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic                sram_WE,
    output logic                sram_CE,
    output logic                sram_OE,
    output logic                sram_LB,
    output logic                sram_UB,
    input  logic [15:0]         sram_io,
    output logic [CHANNELS-1:0] chan_out,
    output logic                speaker,
    output logic                busy,
    output logic                LED,
    output logic                LED2
);

    localparam logic [31:0]    TICK_DEN  = tick_den(CLK_HZ);
    localparam int             WCW       = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(SRAM_WAIT - 1);
    localparam logic [8:0]     BPM_INIT  = 9'(BPM);

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   pc_next;
    logic [15:0]         ir;
    logic [WCW-1:0]      wait_cnt;
    logic [3:0]          dur_cnt;
    logic [8:0]          bpm;
    logic [31:0]         acc;
    logic [31:0]         acc_sum;
    logic                tick;
    logic                start_ok;

    logic [1:0]          ir_op;
    logic [1:0]          ir_ch;
    logic [7:0]          ir_pitch;
    logic [3:0]          ir_dur;
    logic [8:0]          ir_bpm;

    logic [CHANNELS-1:0] ch_load;
    logic [7:0]          ch_pitch;
    logic [CHANNELS-1:0] sounding;

    // Read-only SRAM access.
    assign sram_WE = 1'b1;
    assign sram_CE = 1'b0;
    assign sram_OE = 1'b0;
    assign sram_LB = 1'b0;
    assign sram_UB = 1'b0;

    assign ir_op    = ir[OP_MSB:OP_LSB];
    assign ir_ch    = ir[CH_MSB:CH_LSB];
    assign ir_pitch = ir[PITCH_MSB:PITCH_LSB];
    assign ir_dur   = ir[DUR_MSB:DUR_LSB];
    assign ir_bpm   = ir[TEMPO_MSB:0];

    assign start_ok = start && ((state == S_IDLE) || (state == S_HALT));

    // The sum never overflows: acc stays below TICK_DEN and bpm < 512.
    assign acc_sum = acc + {23'd0, bpm};
    assign tick    = (acc_sum >= TICK_DEN);

    // PC arithmetic wraps naturally at 2^ADDR_W.
    assign pc_inc = pc + ADDR_W'(1);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        pc_next = pc_inc;
`ifdef NOTE_SEQ_JUMP_EN
        if (ir_op == OP_JUMP) begin
            pc_next = ADDR_W'(ir[TARGET_MSB:0]);
        end
`endif
    end

    // Channel load strobes: a NOTE addresses one channel, while END or an
    // accepted start silences all of them by loading pitch 0.
    always_comb begin
        ch_load  = '0;
        ch_pitch = ir_pitch;
        if ((state == S_EXEC) && (ir_op == OP_NOTE)) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (ir_ch == 2'(c)) begin
                    ch_load[c] = 1'b1;
                end
            end
        end
        if (((state == S_EXEC) && (ir_op == OP_END)) || start_ok) begin
            ch_load  = '1;
            ch_pitch = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            sram_addr <= '0;
            ir        <= '0;
            wait_cnt  <= '0;
            dur_cnt   <= '0;
            bpm       <= BPM_INIT;
            acc       <= '0;
            busy      <= 1'b0;
            LED2      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state     <= S_FETCH;
                        pc        <= '0;
                        sram_addr <= '0;
                        wait_cnt  <= '0;
                        bpm       <= BPM_INIT;
                        busy      <= 1'b1;
                        LED2      <= 1'b0;
                    end
                end

                S_FETCH: begin
                    if (wait_cnt == WAIT_LAST) begin
                        ir       <= sram_io;
                        wait_cnt <= '0;
                        state    <= S_EXEC;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end

                S_EXEC: begin
                    // The accumulator restarts here and this cycle counts as
                    // its first increment, so a duration of N ticks puts the
                    // next FETCH exactly N*TICK_DEN/bpm cycles after EXEC.
                    acc <= {23'd0, bpm};
                    case (ir_op)
                        OP_NOTE: begin
                            if (ir_dur == 4'd0) begin
                                pc        <= pc_inc;
                                sram_addr <= pc_inc;
                                state     <= S_FETCH;
                            end else begin
                                dur_cnt <= ir_dur;
                                state   <= S_WAIT;
                            end
                        end
                        OP_JUMP: begin
                            pc        <= pc_next;
                            sram_addr <= pc_next;
                            state     <= S_FETCH;
                        end
                        OP_TEMPO: begin
                            if (ir_bpm != 9'd0) begin
                                bpm <= ir_bpm;
                            end
                            pc        <= pc_inc;
                            sram_addr <= pc_inc;
                            state     <= S_FETCH;
                        end
                        default: begin
                            state <= S_HALT;
                            busy  <= 1'b0;
                            LED2  <= 1'b1;
                        end
                    endcase
                end

                S_WAIT: begin
                    // Subtracting instead of clearing keeps the remainder,
                    // so non-integer tick periods dither without drift.
                    acc <= tick ? (acc_sum - TICK_DEN) : acc_sum;
                    if (tick) begin
                        dur_cnt <= dur_cnt - 4'd1;
                        if (dur_cnt == 4'd1) begin
                            pc        <= pc_inc;
                            sram_addr <= pc_inc;
                            state     <= S_FETCH;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // LED tracks which channels hold a non-zero pitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sounding <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (ch_load[c]) begin
                    sounding[c] <= (ch_pitch != 8'd0);
                end
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        tone_channel #(
            .PERIOD_UNIT(PERIOD_UNIT)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .load (ch_load[c]),
            .pitch(ch_pitch),
            .wave (chan_out[c])
        );
    end

    assign speaker = |chan_out;
    assign LED     = |sounding;

endmodule

// File: tb/tb_note_sequencer.sv
// ---------------------------------------------------------------------------
// tb_note_sequencer
// Scoreboard bench for note_sequencer. Expected fetches (address, cycle) and
// expected output samples (signal, cycle, value) are queued when a program is
// started; a negedge monitor pops and compares them as the DUT runs.
// Expectations for JUMP follow NOTE_SEQ_JUMP_EN.
// ---------------------------------------------------------------------------
module tb_note_sequencer;
    import note_seq_pkg::*;

    localparam int CLK_HZ      = 4000;
    localparam int CHANNELS    = 2;
    localparam int ADDR_W      = 18;
    localparam int SRAM_WAIT   = 2;
    localparam int PERIOD_UNIT = 4;
    localparam int BPM         = 96;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [ADDR_W-1:0]   sram_addr;
    logic                sram_WE, sram_CE, sram_OE, sram_LB, sram_UB;
    logic [15:0]         sram_io;
    logic [CHANNELS-1:0] chan_out;
    logic                speaker, busy, LED, LED2;

    logic [15:0] mem [0:63];
    assign sram_io = mem[sram_addr[5:0]];

    note_sequencer #(
        .CLK_HZ(CLK_HZ), .CHANNELS(CHANNELS), .ADDR_W(ADDR_W),
        .SRAM_WAIT(SRAM_WAIT), .PERIOD_UNIT(PERIOD_UNIT), .BPM(BPM)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .sram_addr(sram_addr),
        .sram_WE(sram_WE), .sram_CE(sram_CE), .sram_OE(sram_OE),
        .sram_LB(sram_LB), .sram_UB(sram_UB),
        .sram_io(sram_io),
        .chan_out(chan_out), .speaker(speaker), .busy(busy),
        .LED(LED), .LED2(LED2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, observed, expected);
        end
    endtask

    typedef enum {SIG_CH0, SIG_CH1, SIG_LED, SIG_LED2, SIG_BUSY, SIG_SPK,
                  SIG_ADDR, SIG_STATE, SIG_CTRL} sig_e;
    typedef struct { int cyc; sig_e sig; logic [31:0] val; } sample_t;
    typedef struct { int cyc; logic [31:0] addr; } fetch_t;

    sample_t sample_q[$];
    fetch_t  fetch_q[$];

    // Keep sample_q ordered by cycle.
    task automatic push(input int c, input sig_e s, input logic [31:0] v);
        sample_t e;
        e.cyc = c; e.sig = s; e.val = v;
        for (int i = 0; i < sample_q.size(); i++) begin
            if (sample_q[i].cyc > c) begin
                sample_q.insert(i, e);
                return;
            end
        end
        sample_q.push_back(e);
    endtask

    task automatic push_fetch(input int c, input int a);
        fetch_t f;
        f.cyc = c; f.addr = 32'(a);
        fetch_q.push_back(f);
    endtask

    function automatic logic [31:0] read_sig(input sig_e s);
        case (s)
            SIG_CH0:   return {31'd0, chan_out[0]};
            SIG_CH1:   return {31'd0, chan_out[1]};
            SIG_LED:   return {31'd0, LED};
            SIG_LED2:  return {31'd0, LED2};
            SIG_BUSY:  return {31'd0, busy};
            SIG_SPK:   return {31'd0, speaker};
            SIG_ADDR:  return 32'(sram_addr);
            SIG_STATE: return 32'(dut.state);
            default:   return {27'd0, sram_WE, sram_CE, sram_OE, sram_LB, sram_UB};
        endcase
    endfunction

    // Monitor: a fetch is the first cycle of a FETCH run.
    state_t prev_state = S_IDLE;
    always @(negedge clk) begin
        if (dut.state == S_FETCH && prev_state != S_FETCH) begin
            if (fetch_q.size() == 0) begin
                check("fetch_extra", 32'(sram_addr), 32'hFFFF_FFFF);
            end else begin
                fetch_t f;
                f = fetch_q.pop_front();
                check("fetch_addr", 32'(sram_addr), f.addr);
                check("fetch_cycle", 32'(cyc), 32'(f.cyc));
            end
        end
        prev_state = dut.state;
        while (sample_q.size() > 0 && sample_q[0].cyc <= cyc) begin
            sample_t e;
            e = sample_q.pop_front();
            check($sformatf("%s@%0d", e.sig.name(), e.cyc), read_sig(e.sig), e.val);
        end
    end

    function automatic logic [15:0] op_note(input int ch, input int pitch, input int dur);
        return {2'b00, 2'(ch), 8'(pitch), 4'(dur)};
    endfunction
    function automatic logic [15:0] op_jump(input int target);
        return {2'b01, 14'(target)};
    endfunction
    function automatic logic [15:0] op_tempo(input int b);
        return {2'b10, 5'd0, 9'(b)};
    endfunction
    localparam logic [15:0] OP_END_W = 16'hC000;

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = OP_END_W;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drained(input string name);
        check({name, "_fetches_left"}, 32'(fetch_q.size()), 32'd0);
        check({name, "_samples_left"}, 32'(sample_q.size()), 32'd0);
    endtask

    // NOTE ch0 pitch 1 dur 2, END. Quarter beat at 96 bpm = 625 cycles.
    task automatic run_prog_a();
        int t;
        clear_mem();
        mem[0] = op_note(0, 1, 2);
        @(negedge clk);
        t = cyc;
        push_fetch(t + 1, 0);
        push_fetch(t + 3 + 1250, 1);
        push(t + 1, SIG_BUSY, 1);
        push(t + 1, SIG_LED2, 0);
        for (int k = t + 4; k <= t + 40; k++)
            push(k, SIG_CH0, 32'(((k - t - 4) / 4) % 2));
        push(t + 20, SIG_CH1, 0);
        push(t + 5, SIG_LED, 1);
        push(t + 1255, SIG_BUSY, 1);
        push(t + 1256, SIG_BUSY, 0);
        push(t + 1255, SIG_LED2, 0);
        push(t + 1256, SIG_LED2, 1);
        push(t + 1258, SIG_SPK, 0);
        push(t + 1258, SIG_LED, 0);
        push(t + 1258, SIG_CH0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // A start while busy must leave the schedule untouched.
        wait_until(t + 100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(t + 1262);
        drained("prog_a");
    endtask

    // TEMPO 192, TEMPO 0 (ignored), NOTE ch0 pitch 0 dur 1, END.
    // 60000/192 = 312.5 -> first tick after 313 accumulations.
    task automatic run_prog_b();
        int t;
        clear_mem();
        mem[0] = op_tempo(192);
        mem[1] = op_tempo(0);
        mem[2] = op_note(0, 0, 1);
        @(negedge clk);
        t = cyc;
        push_fetch(t + 1, 0);
        push_fetch(t + 4, 1);
        push_fetch(t + 7, 2);
        push_fetch(t + 9 + 313, 3);
        push(t + 1, SIG_LED2, 0);
        push(t + 1, SIG_BUSY, 1);
        push(t + 50, SIG_CH0, 0);
        push(t + 50, SIG_LED, 0);
        push(t + 326, SIG_BUSY, 0);
        push(t + 326, SIG_LED2, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(t + 330);
        drained("prog_b");
    endtask

    // NOTE ch0 p2, NOTE ch3 p5 (no such channel), NOTE ch0 p2 again,
    // JUMP 0, NOTE ch0 p1 dur 1, END; then reset in the middle of playback.
    task automatic run_prog_c();
        int t;
        clear_mem();
        mem[0] = op_note(0, 2, 0);
        mem[1] = op_note(3, 5, 0);
        mem[2] = op_note(0, 2, 0);
        mem[3] = op_jump(0);
        mem[4] = op_note(0, 1, 1);
        @(negedge clk);
        t = cyc;
`ifdef NOTE_SEQ_JUMP_EN
        for (int k = 0; k < 20; k++) push_fetch(t + 1 + 3 * k, k % 4);
        for (int k = t + 4; k <= t + 40; k++)
            push(k, SIG_CH0, 32'(((k - t - 4) / 8) % 2));
`else
        for (int k = 0; k < 5; k++) push_fetch(t + 1 + 3 * k, k);
        for (int k = t + 4; k <= t + 40; k++) begin
            if (k <= t + 11)      push(k, SIG_CH0, 0);
            else if (k <= t + 15) push(k, SIG_CH0, 1);
            else                  push(k, SIG_CH0, 32'(((k - t - 16) / 4) % 2));
        end
`endif
        for (int k = t + 4; k <= t + 40; k++) push(k, SIG_CH1, 0);
        push(t + 61, SIG_CH0, 0);
        push(t + 61, SIG_CH1, 0);
        push(t + 61, SIG_BUSY, 0);
        push(t + 61, SIG_LED, 0);
        push(t + 61, SIG_LED2, 0);
        push(t + 61, SIG_SPK, 0);
        push(t + 61, SIG_ADDR, 0);
        push(t + 61, SIG_STATE, 32'(S_IDLE));
        push(t + 70, SIG_BUSY, 0);
        push(t + 70, SIG_STATE, 32'(S_IDLE));
        push(t + 70, SIG_ADDR, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(t + 60);
        rst = 1'b1;
        wait_until(t + 63);
        rst = 1'b0;
        wait_until(t + 75);
        drained("prog_c");
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clear_mem();
        @(negedge clk);
        @(negedge clk);
        push(cyc + 1, SIG_ADDR, 0);
        push(cyc + 1, SIG_CH0, 0);
        push(cyc + 1, SIG_CH1, 0);
        push(cyc + 1, SIG_SPK, 0);
        push(cyc + 1, SIG_BUSY, 0);
        push(cyc + 1, SIG_LED, 0);
        push(cyc + 1, SIG_LED2, 0);
        push(cyc + 1, SIG_STATE, 32'(S_IDLE));
        push(cyc + 1, SIG_CTRL, 32'h10);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push(cyc + 3, SIG_BUSY, 0);
        push(cyc + 3, SIG_STATE, 32'(S_IDLE));
        wait_until(cyc + 4);

        run_prog_a();
        run_prog_b();
        run_prog_a();
        run_prog_c();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 50000", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
